// File: rtl/mem_lsu.sv
// Load/store unit for the MEM stage: accepts one EX-stage access at a time, drives a
// variable-latency req/ack data-memory port, builds byte enables and lane-shifted store
// data, formats loads with sign/zero extension and flags misaligned or illegal accesses.
// Optional macro MEM_TIMEOUT_EN adds a bounded wait on dmem_ack (cause 11 on expiry).
module mem_lsu #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                EX_valid,
    input  logic                EX_Mem_rd_en,
    input  logic                EX_Mem_wr_en,
    input  logic [2:0]          EX_Mem_op,
    input  logic [XLEN-1:0]     EX_ALU_result,
    input  logic [XLEN-1:0]     EX_Rs2_data,
    input  logic                ForwardM,
    input  logic [XLEN-1:0]     WB_Rd_data,
    input  logic                EX_RegFile_wr_en,
    input  logic                EX_MemToReg,
    input  logic [4:0]          EX_Rd_addr,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [ADDR_W-1:0]   dmem_addr,
    output logic [XLEN-1:0]     dmem_wdata,
    output logic [XLEN/8-1:0]   dmem_be,
    input  logic                dmem_ack,
    input  logic [XLEN-1:0]     dmem_rdata,
    output logic                MEM_stall,
    output logic                MEM_valid,
    output logic [XLEN-1:0]     MEM_dout,
    output logic [XLEN-1:0]     MEM_ALU_result,
    output logic                MEM_RegFile_wr_en,
    output logic                MEM_MemToReg,
    output logic [4:0]          MEM_Rd_addr,
    output logic                MEM_Exception,
    output logic [1:0]          MEM_exc_cause
);

    localparam int unsigned NB   = XLEN / 8;
    localparam int unsigned OFFW = $clog2(NB);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e              state_q, state_d;
    // Access captured at acceptance and held stable for the whole WAIT period
    logic [2:0]          op_q, op_d;
    logic [OFFW-1:0]     off_q, off_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]     wdata_q, wdata_d;
    logic [NB-1:0]       be_q, be_d;
    logic [XLEN-1:0]     alu_q, alu_d;
    logic                rf_q, rf_d;
    logic                m2r_q, m2r_d;
    logic [4:0]          rd_q, rd_d;
    // Registered MEM outputs
    logic                valid_q, valid_d;
    logic [XLEN-1:0]     dout_q, dout_d;
    logic [XLEN-1:0]     malu_q, malu_d;
    logic                mrf_q, mrf_d;
    logic                mm2r_q, mm2r_d;
    logic [4:0]          mrd_q, mrd_d;
    logic                exc_q, exc_d;
    logic [1:0]          cause_q, cause_d;
`ifdef MEM_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]       cnt_q, cnt_d;
`endif

    logic                is_mem, op_legal, misalign, accept;
    logic [OFFW-1:0]     off_ex;
    logic [NB-1:0]       be_ex;
    logic [XLEN-1:0]     sdata, wdata_ex, shifted, load_fmt;
    logic [ADDR_W-1:0]   addr_ex;
    int                  size;

    // Decode the EX-stage access: legality, alignment, byte enables and store lanes
    always_comb begin
        is_mem   = EX_Mem_rd_en | EX_Mem_wr_en;
        size     = 1 << EX_Mem_op[1:0];
        off_ex   = EX_ALU_result[OFFW-1:0];
        case (EX_Mem_op)
            3'b011, 3'b110: op_legal = (XLEN == 64);
            3'b111:         op_legal = 1'b0;
            default:        op_legal = 1'b1;
        endcase
        case (EX_Mem_op[1:0])
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = EX_ALU_result[0];
            2'b10:   misalign = |EX_ALU_result[1:0];
            default: misalign = |EX_ALU_result[2:0];
        endcase
        be_ex = '0;
        for (int i = 0; i < int'(NB); i++) begin
            be_ex[i] = (i >= int'(off_ex)) && (i < int'(off_ex) + size);
        end
        sdata    = ForwardM ? WB_Rd_data : EX_Rs2_data;
        wdata_ex = sdata << {off_ex, 3'b000};
        addr_ex  = ADDR_W'(EX_ALU_result) & ~ADDR_W'(NB - 1);
        accept   = (state_q == StIdle) && EX_valid && is_mem && op_legal && !misalign;
    end

    // Select the addressed lane of the returned word and extend it to XLEN
    always_comb begin
        shifted = dmem_rdata >> {off_q, 3'b000};
        case (op_q)
            3'b000:  load_fmt = XLEN'($signed(shifted[7:0]));
            3'b001:  load_fmt = XLEN'($signed(shifted[15:0]));
            3'b010:  load_fmt = XLEN'($signed(shifted[31:0]));
            3'b100:  load_fmt = XLEN'(shifted[7:0]);
            3'b101:  load_fmt = XLEN'(shifted[15:0]);
            3'b110:  load_fmt = XLEN'(shifted[31:0]);
            default: load_fmt = shifted;
        endcase
    end

    // Next-state logic for the IDLE/WAIT controller and all registered fields
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        off_d   = off_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        alu_d   = alu_q;
        rf_d    = rf_q;
        m2r_d   = m2r_q;
        rd_d    = rd_q;
        valid_d = 1'b0;
        dout_d  = dout_q;
        malu_d  = malu_q;
        mrf_d   = mrf_q;
        mm2r_d  = mm2r_q;
        mrd_d   = mrd_q;
        exc_d   = exc_q;
        cause_d = cause_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (EX_valid) begin
                    if (!is_mem || !op_legal || misalign) begin
                        valid_d = 1'b1;
                        dout_d  = '0;
                        malu_d  = EX_ALU_result;
                        mm2r_d  = EX_MemToReg;
                        mrd_d   = EX_Rd_addr;
                        exc_d   = is_mem;
                        cause_d = !is_mem ? 2'b00 : (EX_Mem_rd_en ? 2'b01 : 2'b10);
                        mrf_d   = is_mem ? 1'b0 : EX_RegFile_wr_en;
                    end else begin
                        state_d = StWait;
                        op_d    = EX_Mem_op;
                        off_d   = off_ex;
                        // A request with both enables set is handled as a load
                        we_d    = EX_Mem_wr_en && !EX_Mem_rd_en;
                        addr_d  = addr_ex;
                        wdata_d = wdata_ex;
                        be_d    = be_ex;
                        alu_d   = EX_ALU_result;
                        rf_d    = EX_RegFile_wr_en;
                        m2r_d   = EX_MemToReg;
                        rd_d    = EX_Rd_addr;
`ifdef MEM_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
            end
            StWait: begin
                if (dmem_ack) begin
                    state_d = StIdle;
                    valid_d = 1'b1;
                    dout_d  = we_q ? '0 : load_fmt;
                    malu_d  = alu_q;
                    mrf_d   = rf_q;
                    mm2r_d  = m2r_q;
                    mrd_d   = rd_q;
                    exc_d   = 1'b0;
                    cause_d = 2'b00;
                end
`ifdef MEM_TIMEOUT_EN
                // Expire on the edge that would make the count reach TIMEOUT
                else if (cnt_q == TW'(TIMEOUT - 1)) begin
                    state_d = StIdle;
                    valid_d = 1'b1;
                    dout_d  = '0;
                    malu_d  = alu_q;
                    mrf_d   = 1'b0;
                    mm2r_d  = m2r_q;
                    mrd_d   = rd_q;
                    exc_d   = 1'b1;
                    cause_d = 2'b11;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q <= StIdle;
            op_q    <= '0;
            off_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            alu_q   <= '0;
            rf_q    <= 1'b0;
            m2r_q   <= 1'b0;
            rd_q    <= '0;
            valid_q <= 1'b0;
            dout_q  <= '0;
            malu_q  <= '0;
            mrf_q   <= 1'b0;
            mm2r_q  <= 1'b0;
            mrd_q   <= '0;
            exc_q   <= 1'b0;
            cause_q <= '0;
`ifdef MEM_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            off_q   <= off_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            alu_q   <= alu_d;
            rf_q    <= rf_d;
            m2r_q   <= m2r_d;
            rd_q    <= rd_d;
            valid_q <= valid_d;
            dout_q  <= dout_d;
            malu_q  <= malu_d;
            mrf_q   <= mrf_d;
            mm2r_q  <= mm2r_d;
            mrd_q   <= mrd_d;
            exc_q   <= exc_d;
            cause_q <= cause_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Memory port is driven only while waiting, so it reads all-zero when idle
    always_comb begin
        dmem_req          = (state_q == StWait);
        dmem_we           = dmem_req & we_q;
        dmem_addr         = dmem_req ? addr_q : '0;
        dmem_wdata        = dmem_req ? wdata_q : '0;
        dmem_be           = dmem_req ? be_q : '0;
        MEM_stall         = dmem_req | accept;
        MEM_valid         = valid_q;
        MEM_dout          = dout_q;
        MEM_ALU_result    = malu_q;
        MEM_RegFile_wr_en = mrf_q;
        MEM_MemToReg      = mm2r_q;
        MEM_Rd_addr       = mrd_q;
        MEM_Exception     = exc_q;
        MEM_exc_cause     = cause_q;
    end

endmodule
